// File: rtl/keypad_entry_ctrl.sv
// Operand-entry controller: decodes buffered 4x4 keypad presses into two
// decimal operands and hands the pair downstream through ops_valid/ops_ready.
module keypad_entry_ctrl #(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 3,
  parameter int OP_W   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pressed_col,
  input  logic [WIDTH-1:0] pressed_row,
  input  logic             pressed_valid,
  output logic             ack_read,
  output logic [OP_W-1:0]  op_a,
  output logic [OP_W-1:0]  op_b,
  output logic             ops_valid,
  input  logic             ops_ready,
  output logic [OP_W-1:0]  cur_value,
  output logic             cur_sel,
  output logic [1:0]       digit_cnt,
  output logic             key_err
);

  typedef enum logic [1:0] {
    S_ENTRY     = 2'd0,
    S_WAIT_DROP = 2'd1,
    S_DONE      = 2'd2
  } state_t;

  localparam logic [1:0]      DIGITS_C = 2'(DIGITS);
  localparam logic [OP_W-1:0] TEN      = OP_W'(10);

  state_t          state_q, state_d;
  logic            ret_done_q, ret_done_d;
  logic            cur_sel_q, cur_sel_d;
  logic [OP_W-1:0] op_a_q, op_a_d;
  logic [OP_W-1:0] op_b_q, op_b_d;
  logic [OP_W-1:0] cur_q, cur_d;
  logic [1:0]      digit_cnt_q, digit_cnt_d;
  logic            ack_q, ack_d;
  logic            key_err_q, key_err_d;

  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [1:0] enc(input logic [WIDTH-1:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  logic       key_ok;
  logic [1:0] row_idx, col_idx;
  logic       is_digit, is_star, is_hash;
  logic [3:0] digit_val;

  // Key map: rows 0..2 hold 1..9 in the first three columns, row 3 is * 0 #,
  // column 3 is the letter column A..D which is always discarded.
  always_comb begin
    key_ok    = is_onehot(pressed_row) && is_onehot(pressed_col);
    row_idx   = enc(pressed_row);
    col_idx   = enc(pressed_col);
    is_digit  = 1'b0;
    is_star   = 1'b0;
    is_hash   = 1'b0;
    digit_val = 4'd0;
    if (row_idx != 2'd3 && col_idx != 2'd3) begin
      is_digit  = 1'b1;
      digit_val = {2'b00, row_idx} * 4'd3 + {2'b00, col_idx} + 4'd1;
    end else if (row_idx == 2'd3) begin
      is_digit = (col_idx == 2'd1);
      is_star  = (col_idx == 2'd0);
      is_hash  = (col_idx == 2'd2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_ENTRY;
      ret_done_q  <= 1'b0;
      cur_sel_q   <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      cur_q       <= '0;
      digit_cnt_q <= 2'd0;
      ack_q       <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_done_q  <= ret_done_d;
      cur_sel_q   <= cur_sel_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      cur_q       <= cur_d;
      digit_cnt_q <= digit_cnt_d;
      ack_q       <= ack_d;
      key_err_q   <= key_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ret_done_d  = ret_done_q;
    cur_sel_d   = cur_sel_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    cur_d       = cur_q;
    digit_cnt_d = digit_cnt_q;
    ack_d       = 1'b0;
    key_err_d   = 1'b0;
    case (state_q)
      S_ENTRY: begin
        if (pressed_valid) begin
          ack_d      = 1'b1;
          ret_done_d = 1'b0;
          state_d    = S_WAIT_DROP;
          if (!key_ok) begin
            key_err_d = 1'b1;
          end else if (is_digit) begin
            if (digit_cnt_q < DIGITS_C) begin
              cur_d       = cur_q * TEN + {{(OP_W-4){1'b0}}, digit_val};
              digit_cnt_d = digit_cnt_q + 2'd1;
            end
          end else if (is_star) begin
            cur_d       = '0;
            digit_cnt_d = 2'd0;
          end else if (is_hash && digit_cnt_q != 2'd0) begin
            cur_d       = '0;
            digit_cnt_d = 2'd0;
            if (!cur_sel_q) begin
              op_a_d    = cur_q;
              cur_sel_d = 1'b1;
            end else begin
              op_b_d     = cur_q;
              ret_done_d = 1'b1;
            end
          end
        end
      end
      // Stay here until the upstream buffer has dropped the key just acked,
      // so a stale pressed_valid is never taken as a second key.
      S_WAIT_DROP: begin
        if (!pressed_valid) state_d = ret_done_q ? S_DONE : S_ENTRY;
      end
      S_DONE: begin
        if (ops_ready) begin
          op_a_d      = '0;
          op_b_d      = '0;
          cur_d       = '0;
          digit_cnt_d = 2'd0;
          cur_sel_d   = 1'b0;
          state_d     = S_ENTRY;
        end
      end
      default: state_d = S_ENTRY;
    endcase
  end

  assign ack_read  = ack_q;
  assign key_err   = key_err_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign ops_valid = (state_q == S_DONE);
  assign cur_value = (state_q == S_DONE) ? op_b_q : cur_q;
  assign cur_sel   = cur_sel_q;
  assign digit_cnt = digit_cnt_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed scenarios then random keys, checked
// against a digit-queue model of the operand entry rules.
module tb_keypad_entry_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pressed_col, pressed_row;
  logic       pressed_valid, ops_ready;
  logic       ack_read, ops_valid, cur_sel, key_err;
  logic [9:0] op_a, op_b, cur_value;
  logic [1:0] digit_cnt;

  keypad_entry_ctrl #(.WIDTH(4), .DIGITS(3), .OP_W(10)) dut (
    .clk(clk), .rst(rst),
    .pressed_col(pressed_col), .pressed_row(pressed_row),
    .pressed_valid(pressed_valid), .ack_read(ack_read),
    .op_a(op_a), .op_b(op_b), .ops_valid(ops_valid), .ops_ready(ops_ready),
    .cur_value(cur_value), .cur_sel(cur_sel), .digit_cnt(digit_cnt),
    .key_err(key_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ack_total = 0;

  always @(negedge clk) if (ack_read === 1'b1) ack_total++;

  // Reference model: digits typed into the current operand, kept as a queue.
  int    q[$];
  int    m_sel, m_opa, m_opb, m_done;
  string keymap[4] = '{"123A", "456B", "789C", "*0#D"};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int qval();
    int v = 0;
    foreach (q[i]) v = v * 10 + q[i];
    return v;
  endfunction

  function automatic void model_clear();
    q.delete();
    m_sel = 0; m_opa = 0; m_opb = 0; m_done = 0;
  endfunction

  function automatic bit model_key(input logic [3:0] row, input logic [3:0] col);
    byte ch;
    if (!$onehot(row) || !$onehot(col)) return 1'b1;
    ch = keymap[$clog2(row)][$clog2(col)];
    if (ch >= "0" && ch <= "9") begin
      if (q.size() < 3) q.push_back(int'(ch - "0"));
    end else if (ch == "*") begin
      q.delete();
    end else if (ch == "#" && q.size() > 0) begin
      if (m_sel == 0) begin m_opa = qval(); m_sel = 1; end
      else begin m_opb = qval(); m_done = 1; end
      q.delete();
    end
    return 1'b0;
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".cur_value"}, 32'(cur_value), 32'(m_done ? m_opb : qval()));
    check({tag, ".digit_cnt"}, 32'(digit_cnt), 32'(q.size()));
    check({tag, ".cur_sel"},   32'(cur_sel),   32'(m_sel));
    check({tag, ".op_a"},      32'(op_a),      32'(m_opa));
    check({tag, ".op_b"},      32'(op_b),      32'(m_opb));
    check({tag, ".ops_valid"}, 32'(ops_valid), 32'(m_done));
  endtask

  // Upstream side of the handshake: wait for the ack, keep the key pending
  // for `hold` extra cycles, drop it, then compare with the model.
  task automatic finish_key(input int hold, input bit exp_err, input string tag);
    int n = 0;
    bit got = 0;
    while (n < 10 && !got) begin
      @(negedge clk);
      n++;
      if (ack_read === 1'b1) got = 1;
    end
    check({tag, ".ack_seen"}, 32'(got), 32'd1);
    check({tag, ".key_err"}, 32'(key_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".held_no_ack"}, 32'(ack_read), 32'd0);
      check({tag, ".err_pulse"}, 32'(key_err), 32'd0);
    end
    pressed_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_state(tag);
    $display("key row=%b col=%b hold=%0d cur=%0d cnt=%0d sel=%0d a=%0d b=%0d valid=%0d",
             pressed_row, pressed_col, hold, cur_value, digit_cnt, cur_sel, op_a, op_b, ops_valid);
  endtask

  task automatic press_raw(input logic [3:0] row, input logic [3:0] col, input int hold,
                           input string tag);
    bit e;
    pressed_row = row;
    pressed_col = col;
    pressed_valid = 1'b1;
    e = model_key(row, col);
    finish_key(hold, e, tag);
  endtask

  task automatic press(input byte ch, input int hold, input string tag);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keymap[r][c] == ch) begin
          press_raw(4'(1 << r), 4'(1 << c), hold, tag);
          return;
        end
  endtask

  task automatic accept_pair(input string tag);
    check({tag, ".ops_valid_before"}, 32'(ops_valid), 32'd1);
    ops_ready = 1'b1;
    @(negedge clk);
    ops_ready = 1'b0;
    model_clear();
    check({tag, ".ops_valid_after"}, 32'(ops_valid), 32'd0);
    check({tag, ".op_a_cleared"}, 32'(op_a), 32'd0);
    $display("accept pair: ops_valid=%0d", ops_valid);
  endtask

  initial begin
    int acks0;
    logic [9:0] a_snap, b_snap;
    bit e;
    logic [3:0] bad_rows[5] = '{4'b0000, 4'b0011, 4'b0101, 4'b1111, 4'b1100};

    rst = 1'b1;
    pressed_row = 4'd0; pressed_col = 4'd0; pressed_valid = 1'b0; ops_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check("rst.ack", 32'(ack_read), 32'd0);
    check("rst.key_err", 32'(key_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_state("reset");

    // 1 2 3 # 4 5 #
    acks0 = ack_total;
    press("1", 0, "seq1"); press("2", 0, "seq1"); press("3", 0, "seq1");
    press("#", 0, "seq1"); press("4", 0, "seq1"); press("5", 0, "seq1");
    press("#", 0, "seq1");
    check("seq1.op_a", 32'(op_a), 32'd123);
    check("seq1.op_b", 32'(op_b), 32'd45);
    check("seq1.ack_count", 32'(ack_total - acks0), 32'd7);

    // Key pending in DONE is held off until the pair is accepted
    a_snap = op_a; b_snap = op_b;
    pressed_row = 4'b0100; pressed_col = 4'b0001; pressed_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("done.no_ack", 32'(ack_read), 32'd0);
      check("done.ops_valid", 32'(ops_valid), 32'd1);
      check("done.op_a_stable", 32'(op_a), 32'(a_snap));
      check("done.op_b_stable", 32'(op_b), 32'(b_snap));
    end
    accept_pair("done");
    e = model_key(pressed_row, pressed_col);
    finish_key(0, e, "pending7");

    // Digit overflow and clear
    press("*", 0, "clr");
    press("9", 1, "ovf"); press("8", 0, "ovf"); press("7", 2, "ovf"); press("6", 0, "ovf");
    check("ovf.cur_value", 32'(cur_value), 32'd987);
    check("ovf.digit_cnt", 32'(digit_cnt), 32'd3);
    press("*", 0, "star");
    check("star.cur_value", 32'(cur_value), 32'd0);

    // Invalid encoding, then enter with no digits
    press("4", 0, "pre_err");
    press_raw(4'b0011, 4'b0010, 0, "bad_row");
    check("bad_row.cur_value", 32'(cur_value), 32'd4);
    press("*", 0, "clr2");
    press("#", 0, "empty_hash");
    check("empty_hash.cur_sel", 32'(cur_sel), 32'd0);

    // Async reset in the middle of WAIT_DROP, key still pending afterwards
    pressed_row = 4'b0010; pressed_col = 4'b0010; pressed_valid = 1'b1;
    begin
      int n = 0;
      bit got = 0;
      while (n < 10 && !got) begin
        @(negedge clk); n++;
        if (ack_read === 1'b1) got = 1;
      end
      check("rst_mid.ack_seen", 32'(got), 32'd1);
    end
    #2 rst = 1'b1;
    #1;
    check("rst_mid.cur_value", 32'(cur_value), 32'd0);
    check("rst_mid.digit_cnt", 32'(digit_cnt), 32'd0);
    check("rst_mid.ack", 32'(ack_read), 32'd0);
    check("rst_mid.ops_valid", 32'(ops_valid), 32'd0);
    check("rst_mid.op_a", 32'(op_a), 32'd0);
    check("rst_mid.cur_sel", 32'(cur_sel), 32'd0);
    $display("async reset mid-wait: cur=%0d cnt=%0d ack=%0d", cur_value, digit_cnt, ack_read);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    e = model_key(pressed_row, pressed_col);
    finish_key(0, e, "after_rst");

    // Random keys with random extra hold of the stale pending flag
    for (int it = 0; it < 60; it++) begin
      if (m_done) begin
        accept_pair("rand_accept");
      end else begin
        int sel = $urandom_range(0, 9);
        int hold = $urandom_range(0, 2);
        if (sel == 0)
          press_raw(bad_rows[$urandom_range(0, 4)], 4'(1 << $urandom_range(0, 3)), hold, "rand_bad");
        else if (sel <= 2)
          press("#", hold, "rand_hash");
        else
          press_raw(4'(1 << $urandom_range(0, 3)), 4'(1 << $urandom_range(0, 3)), hold, "rand_key");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
